// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes instruction-fetch and data accesses onto one single-port memory.
// Optional macro MEM_ARB_IBUF_EN adds a one-entry fetch buffer that can answer repeat fetches.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int SW = (MAX_DSTREAK < 1) ? 1 : $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0] DMAX = SW'(MAX_DSTREAK);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [SW-1:0]     dstreak_r, dstreak_s;
    logic              mem_we_r, mem_we_s;
    logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_r, mem_wdata_s;
    logic              d_win_s;
    logic              grant_d_s;
    logic              ack_i_s;
    logic              ack_d_s;
    logic              buf_match_s;
    logic              hit_s;

    // Data wins unless a pending fetch has already waited out MAX_DSTREAK data grants.
    assign d_win_s = d_req && !(if_req && (dstreak_r == DMAX));
    assign ack_i_s = (state_r == I_ACC) && mem_ack && !reset;
    assign ack_d_s = (state_r == D_ACC) && mem_ack && !reset;
    assign hit_s   = (state_r == IDLE) && !reset && !d_win_s && if_req && buf_match_s;

`ifdef MEM_ARB_IBUF_EN
    logic              buf_valid_r;
    logic [ADDR_W-1:0] buf_addr_r;
    logic [DATA_W-1:0] buf_data_r;

    assign buf_match_s = buf_valid_r && (if_addr == buf_addr_r);

    // Fetch buffer: filled by every completed fetch, invalidated by a store to the same word.
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_r <= 1'b0;
            buf_addr_r  <= {ADDR_W{1'b0}};
            buf_data_r  <= {DATA_W{1'b0}};
        end else if (ack_i_s) begin
            buf_valid_r <= 1'b1;
            buf_addr_r  <= mem_addr_r;
            buf_data_r  <= mem_rdata;
        end else if (grant_d_s && d_we && (d_addr == buf_addr_r)) begin
            buf_valid_r <= 1'b0;
        end
    end
`else
    assign buf_match_s = 1'b0;
`endif

    // Next-state, streak and memory-command selection.
    always_comb begin
        state_s     = state_r;
        dstreak_s   = dstreak_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        grant_d_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_win_s) begin
                    grant_d_s   = 1'b1;
                    state_s     = D_ACC;
                    mem_we_s    = d_we;
                    mem_addr_s  = d_addr;
                    mem_wdata_s = d_wdata;
                    // A granted data access with a fetch waiting is always below DMAX here.
                    if (if_req) begin
                        dstreak_s = dstreak_r + SW'(1);
                    end else begin
                        dstreak_s = {SW{1'b0}};
                    end
                end else if (if_req) begin
                    dstreak_s = {SW{1'b0}};
                    if (buf_match_s) begin
                        state_s = IDLE;
                    end else begin
                        state_s    = I_ACC;
                        mem_we_s   = 1'b0;
                        mem_addr_s = if_addr;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            I_ACC: begin
                if (mem_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = I_ACC;
                end
            end
            D_ACC: begin
                if (mem_ack) begin
                    state_s = IDLE;
                end else begin
                    state_s = D_ACC;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and memory-command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            dstreak_r   <= {SW{1'b0}};
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            dstreak_r   <= dstreak_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
        end
    end

    // Completion pulses with read data passed straight through from memory (or the buffer).
    always_comb begin
        if_valid = 1'b0;
        if_rdata = {DATA_W{1'b0}};
        d_done   = 1'b0;
        d_rdata  = {DATA_W{1'b0}};
        if (ack_i_s) begin
            if_valid = 1'b1;
            if_rdata = mem_rdata;
        end else if (hit_s) begin
            if_valid = 1'b1;
`ifdef MEM_ARB_IBUF_EN
            if_rdata = buf_data_r;
`endif
        end else begin
            if_valid = 1'b0;
        end
        if (ack_d_s) begin
            d_done  = 1'b1;
            d_rdata = mem_rdata;
        end else begin
            d_done = 1'b0;
        end
    end

    assign mem_req   = (state_r != IDLE);
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_stall  = if_req & ~if_valid;
    assign d_stall   = d_req & ~d_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a memory responder and access/response scoreboards.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        if_stall;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] wdata; } acc_t;
    typedef struct packed { logic is_d; logic [31:0] data; logic chk; } resp_t;

    acc_t        acc_q[$];
    resp_t       exp_q[$];
    logic [31:0] mem_m [logic [31:0]];
    int          total = 0;
    int          passed = 0;
    int          lat = 1;
    bit          manual = 1'b0;
    bit          d_hold = 1'b0;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_m.exists(a)) return mem_m[a];
        return {a[15:0], 16'h5A5A};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic push_acc(input logic we, input logic [31:0] a, input logic [31:0] wd);
        acc_t x;
        x.we = we; x.addr = a; x.wdata = wd;
        acc_q.push_back(x);
    endtask

    task automatic push_resp(input logic is_d, input logic [31:0] data, input logic chk);
        resp_t x;
        x.is_d = is_d; x.data = data; x.chk = chk;
        exp_q.push_back(x);
    endtask

    task automatic wait_clear(input string tag, input int budget);
        int n;
        n = 0;
        while ((if_req || d_req) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_completed"}, {63'd0, (if_req || d_req)}, 64'd0);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
    endtask

    // Memory model: acks after 'lat' cycles of mem_req, unless the main sequence drives it by hand.
    initial begin : responder
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            if (!manual) begin
                mem_ack = 1'b0;
                mem_rdata = 32'h0;
                if (mem_req === 1'b1) begin
                    cnt++;
                    if (cnt >= lat) begin
                        cnt = 0;
                        mem_ack = 1'b1;
                        if (mem_we) mem_m[mem_addr] = mem_wdata;
                        else mem_rdata = mem_rd(mem_addr);
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Core side: drop a request once its completion has been seen.
    initial begin : core_drop
        bit di, dd;
        forever begin
            @(negedge clk);
            di = (if_valid === 1'b1);
            dd = (d_done === 1'b1);
            @(posedge clk);
            #1;
            if (di) if_req = 1'b0;
            if (dd && !d_hold) d_req = 1'b0;
        end
    end

    // Scoreboard: memory commands in grant order, completions in order with data.
    initial begin : monitor
        acc_t  a;
        resp_t r;
        logic  prev_req;
        prev_req = 1'b0;
        a = '0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && prev_req !== 1'b1) begin
                check("access_expected", {63'd0, acc_q.size() != 0}, 64'd1);
                if (acc_q.size() != 0) begin
                    a = acc_q.pop_front();
                    check("acc_we", {63'd0, mem_we}, {63'd0, a.we});
                    check("acc_addr", {32'd0, mem_addr}, {32'd0, a.addr});
                    if (a.we) check("acc_wdata", {32'd0, mem_wdata}, {32'd0, a.wdata});
                end
            end else if (mem_req === 1'b1) begin
                check("acc_stable", {31'd0, mem_we, mem_addr}, {31'd0, a.we, a.addr});
                if (a.we) check("acc_wdata_stable", {32'd0, mem_wdata}, {32'd0, a.wdata});
            end
            if (if_valid === 1'b1) begin
                check("if_resp_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    check("resp_port_i", {63'd0, r.is_d}, 64'd0);
                    check("if_rdata", {32'd0, if_rdata}, {32'd0, r.data});
                end
            end
            if (d_done === 1'b1) begin
                check("d_resp_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    r = exp_q.pop_front();
                    check("resp_port_d", {63'd0, r.is_d}, 64'd1);
                    if (r.chk) check("d_rdata", {32'd0, d_rdata}, {32'd0, r.data});
                end
            end
            prev_req = mem_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, cyc, nreq, nst;
        bit done;
        reset = 1'b1;
        if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_m[32'h10] = 32'hE3A00005;
        mem_m[32'h80] = 32'hCAFEF00D;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {58'd0, mem_req, mem_we, if_valid, d_done, if_stall, d_stall}, 64'd0);
        check("reset_mem_addr", {32'd0, mem_addr}, 64'd0);
        check("reset_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        check("reset_rdata", {if_rdata, d_rdata}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Fetch only, 1-cycle memory
        @(posedge clk); #1;
        if_addr = 32'h10;
        push_acc(1'b0, 32'h10, 32'h0);
        push_resp(1'b0, 32'hE3A00005, 1'b1);
        if_req = 1'b1;
        @(negedge clk);
        check("t1_c0", {61'd0, if_stall, if_valid, mem_req}, 64'b100);
        @(negedge clk);
        check("t1_c1", {61'd0, if_stall, if_valid, mem_req}, 64'b011);
        @(negedge clk);
        check("t1_c2", {61'd0, if_stall, if_valid, mem_req}, 64'b000);
        wait_clear("t1", 20);

        // Simultaneous store and fetch: data first
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678; if_addr = 32'h10;
        push_acc(1'b1, 32'h40, 32'h12345678);
        push_acc(1'b0, 32'h10, 32'h0);
        push_resp(1'b1, 32'h0, 1'b0);
        push_resp(1'b0, 32'hE3A00005, 1'b1);
        d_req = 1'b1; if_req = 1'b1;
        @(negedge clk);
        check("t2_both_stall", {62'd0, if_stall, d_stall}, 64'b11);
        @(negedge clk);
        check("t2_d_first", {61'd0, d_done, if_valid, if_stall}, 64'b101);
        wait_clear("t2", 20);

        // Continuous data traffic with a pending fetch: 4 D, 1 I, then D again
        @(posedge clk); #1;
        d_hold = 1'b1; d_we = 1'b0; d_addr = 32'h100; if_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            push_acc(1'b0, 32'h100, 32'h0);
            push_resp(1'b1, mem_rd(32'h100), 1'b1);
        end
        push_acc(1'b0, 32'h20, 32'h0);
        push_resp(1'b0, mem_rd(32'h20), 1'b1);
        for (int i = 0; i < 2; i++) begin
            push_acc(1'b0, 32'h100, 32'h0);
            push_resp(1'b1, mem_rd(32'h100), 1'b1);
        end
        d_req = 1'b1; if_req = 1'b1;
        n = 0; cyc = 0;
        while (n < 6 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (d_done === 1'b1) n++;
        end
        d_hold = 1'b0;
        check("t3_d_count", n, 64'd6);
        wait_clear("t3", 20);

        // Slow memory (5 cycles) on a load
        lat = 5;
        @(posedge clk); #1;
        d_we = 1'b0; d_addr = 32'h80;
        push_acc(1'b0, 32'h80, 32'h0);
        push_resp(1'b1, 32'hCAFEF00D, 1'b1);
        d_req = 1'b1;
        nreq = 0; nst = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_req === 1'b1) nreq++;
            if (d_stall === 1'b1) nst++;
            if (d_done === 1'b1) done = 1'b1;
        end
        check("t4_mem_req_cycles", nreq, 64'd5);
        check("t4_stall_cycles", nst, 64'd5);
        wait_clear("t4", 20);
        lat = 1;

        // Reset in the second cycle of a data access, then a stale ack
        manual = 1'b1;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        @(posedge clk); #1;
        d_we = 1'b0; d_addr = 32'h84;
        push_acc(1'b0, 32'h84, 32'h0);
        d_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        check("t5_still_in_access", {63'd0, mem_req}, 64'd1);
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        check("t5_abandon", {61'd0, mem_req, d_done, if_valid}, 64'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'h0; manual = 1'b0;
        @(negedge clk);
        check("t5_idle_after_stale", {62'd0, mem_req, d_done}, 64'd0);
        @(posedge clk); #1;
        d_we = 1'b0; d_addr = 32'h40;
        push_acc(1'b0, 32'h40, 32'h0);
        push_resp(1'b1, 32'h12345678, 1'b1);
        d_req = 1'b1;
        wait_clear("t5_next", 20);

        // Repeat fetch, then store to the fetched word and refetch
        @(posedge clk); #1;
        if_addr = 32'h10;
        push_acc(1'b0, 32'h10, 32'h0);
        push_resp(1'b0, 32'hE3A00005, 1'b1);
        if_req = 1'b1;
        wait_clear("t6_first", 20);
        @(posedge clk); #1;
        push_resp(1'b0, 32'hE3A00005, 1'b1);
`ifdef MEM_ARB_IBUF_EN
        if_req = 1'b1;
        @(negedge clk);
        check("t6_buf_hit", {61'd0, if_valid, mem_req, if_stall}, 64'b100);
`else
        push_acc(1'b0, 32'h10, 32'h0);
        if_req = 1'b1;
        @(negedge clk);
        check("t6_refetch_c0", {61'd0, if_valid, mem_req, if_stall}, 64'b001);
`endif
        wait_clear("t6_second", 20);
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
        push_acc(1'b1, 32'h10, 32'hDEADBEEF);
        push_resp(1'b1, 32'h0, 1'b0);
        d_req = 1'b1;
        wait_clear("t6_store", 20);
        @(posedge clk); #1;
        push_acc(1'b0, 32'h10, 32'h0);
        push_resp(1'b0, 32'hDEADBEEF, 1'b1);
        if_req = 1'b1;
        @(negedge clk);
        check("t6_after_store", {61'd0, if_valid, mem_req, if_stall}, 64'b001);
        wait_clear("t6_refetch", 20);

        repeat (3) @(negedge clk);
        check("acc_q_empty", acc_q.size(), 64'd0);
        check("exp_q_empty", exp_q.size(), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
